// File: rtl/axis_loopback_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axis_loopback_buffer                                              |
// | Brief  : AXI-Stream byte path with bypass, FIFO, line and drop-on-full     |
// |          modes, overflow counter and retriggerable activity LED.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module axis_loopback_buffer #(
   parameter int         DATA_W     = 8,
   parameter int         DEPTH_LOG2 = 4,
   parameter logic [7:0] TERM_CHAR  = 8'h0D,
   parameter int         LED_HOLD   = 4000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            mode,
   input  logic [DATA_W-1:0]     i_tdata,
   input  logic                  i_tvalid,
   output logic                  i_tready,
   output logic [DATA_W-1:0]     o_tdata,
   output logic                  o_tvalid,
   input  logic                  o_tready,
   output logic [DEPTH_LOG2:0]   fill,
   output logic [15:0]           overflow_cnt,
   output logic                  led
);

   localparam int c_depth  = 2 ** DEPTH_LOG2;
   localparam int c_led_w  = $clog2(LED_HOLD + 1);

   localparam logic [1:0] c_mode_bypass = 2'd0;
   localparam logic [1:0] c_mode_fifo   = 2'd1;
   localparam logic [1:0] c_mode_line   = 2'd2;
   localparam logic [1:0] c_mode_drop   = 2'd3;

   localparam logic [0:0] c_st_fill  = 1'b0;
   localparam logic [0:0] c_st_drain = 1'b1;

   localparam logic [DEPTH_LOG2:0] c_fill_full = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] c_fill_last = c_fill_full - 1'b1;
   localparam logic [DEPTH_LOG2:0] c_fill_one  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [c_led_w-1:0]  c_led_hold  = c_led_w'(LED_HOLD);

   logic [DATA_W-1:0]     r_mem [c_depth];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_fill;
   logic [1:0]            r_mode_q;
   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic [15:0]           r_ovf;
   logic [c_led_w-1:0]    r_led_cnt;

   logic w_full;
   logic w_empty;
   logic w_bypass;
   logic w_term;
   logic w_in_rdy;
   logic w_fifo_vld;
   logic w_in_xfer;
   logic w_out_xfer;
   logic w_push;
   logic w_pop;
   logic w_drop;
   logic w_line_accept;
   logic w_line_emit;

   assign w_full   = (r_fill == c_fill_full);
   assign w_empty  = (r_fill == '0);
   assign w_bypass = (r_mode_q == c_mode_bypass);
   assign w_term   = (i_tdata[7:0] == TERM_CHAR);

   // Handshake selection per latched mode; rst_n gates both directions so
   // nothing is offered or accepted while reset is held.
   always_comb begin
      w_in_rdy   = 1'b0;
      w_fifo_vld = 1'b0;
      case (r_mode_q)
         c_mode_bypass: begin
            w_in_rdy = o_tready;
         end
         c_mode_fifo: begin
            w_in_rdy   = !w_full;
            w_fifo_vld = !w_empty;
         end
         c_mode_line: begin
            w_in_rdy   = w_line_accept && !w_full;
            w_fifo_vld = w_line_emit && !w_empty;
         end
         c_mode_drop: begin
            w_in_rdy   = 1'b1;
            w_fifo_vld = !w_empty;
         end
         default: begin
            w_in_rdy   = 1'b0;
            w_fifo_vld = 1'b0;
         end
      endcase
   end

   assign i_tready = rst_n & w_in_rdy;
   assign o_tvalid = rst_n & (w_bypass ? i_tvalid : w_fifo_vld);
   assign o_tdata  = w_bypass   ? i_tdata :
                     w_fifo_vld ? r_mem[r_rd_ptr] : '0;

   assign w_in_xfer  = i_tvalid & i_tready;
   assign w_out_xfer = o_tvalid & o_tready;
   assign w_pop      = w_out_xfer & !w_bypass;
   // A pop in the same cycle frees the slot, so a push at full is still stored.
   assign w_push     = w_in_xfer & !w_bypass & (!w_full | w_pop);
   assign w_drop     = w_in_xfer & (r_mode_q == c_mode_drop) & w_full & !w_pop;

   // Line FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_fill;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Line FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_fill: begin
            if ((r_mode_q == c_mode_line) && w_push &&
                (w_term || (r_fill == c_fill_last))) begin
               w_state_nxt = c_st_drain;
            end
         end
         c_st_drain: begin
            if (w_pop && (r_fill == c_fill_one)) begin
               w_state_nxt = c_st_fill;
            end
         end
         default: w_state_nxt = c_st_fill;
      endcase
   end

   // Line FSM: outputs
   always_comb begin
      w_line_accept = 1'b0;
      w_line_emit   = 1'b0;
      case (r_state)
         c_st_fill:  w_line_accept = 1'b1;
         c_st_drain: w_line_emit   = 1'b1;
         default: begin
            w_line_accept = 1'b0;
            w_line_emit   = 1'b0;
         end
      endcase
   end

   // Mode only changes when nothing is buffered and no byte is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_q <= c_mode_bypass;
      end else if (w_empty && (r_state == c_st_fill) && !w_in_xfer) begin
         r_mode_q <= mode;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_tdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= '0;
      end else if (w_drop && (r_ovf != 16'hFFFF)) begin
         r_ovf <= r_ovf + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led_cnt <= '0;
      end else if (w_out_xfer) begin
         r_led_cnt <= c_led_hold;
      end else if (r_led_cnt != '0) begin
         r_led_cnt <= r_led_cnt - 1'b1;
      end
   end

   assign fill         = r_fill;
   assign overflow_cnt = r_ovf;
   assign led          = (r_led_cnt != '0);

endmodule
`default_nettype wire
